instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Program-load side of the 9-bit ISA. Accepts symbolic instructions (op, reg, imm fields) over a
//  valid/ready handshake and encodes each into 9-bit machine code, bit-exact with the Ctrl decoder.
//  Writes the words sequentially into instruction memory from address 0, then stops on halt or full.
//  Sits between the bench/boot loader and instr ROM write port; exact inverse of Ctrl's field decode.
// PARAMETERS
//  A      8    instruction memory address width
//  DEPTH  256  words writable (must be <= 2**A)
// PORTS
//  Clk       in   1   clock, all state on rising edge
//  Reset     in   1   asynchronous, active-low reset
//  Start     in   1   1-cycle pulse: clear addr/flags, begin loading
//  InValid   in   1   instruction fields valid
//  InReady   out  1   encoder can accept this cycle
//  InOp      in   5   0 LSL,1 LSR,2 XOR,3 RXR,4 LD,5 ST,6 JE,7 JNE,8 SPC,9 LUT,10 CTC,11 CPY,
//                     12 OR,13 ADD,14 SUB,15 MOV,16 HALT, 17-31 illegal
//  InRd      in   3   dest/operand reg (shift dst, xor/rxr/or/add/cpy/lut reg, ld/st reg)
//  InRs      in   3   LSL/LSR src reg; OR src (legal 0-3); JE/JNE/SPC pc-reg select (legal 1-3)
//  InImm     in   5   MOV immediate
//  InFlag    in   1   SPC offset-enable; LUT 0=LSW 1=MSW
//  ImWrEn    out  1   instr memory write strobe
//  ImWrAddr  out  A   write address
//  ImWrData  out  9   encoded word
//  Count     out  A+1 words written since Start
//  Done      out  1   loading finished (halt written or full)
//  Full      out  1   DEPTH words written without halt
//  Error     out  1   illegal op/field rejected
//  Checksum  out  9   see CONFIGURATION
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; InReady/ImWrEn/Done/Full/Error=0; ImWrAddr/Count/Checksum=0.
//  FSM: IDLE -Start-> ACCEPT; ACCEPT -accept,legal-> WRITE; ACCEPT -accept,illegal-> ERR;
//   WRITE -> ACCEPT, or DONE if word was HALT or Count reaches DEPTH. DONE/ERR hold until Start.
//  Start in any state: addr/Count/Checksum/flags cleared, go ACCEPT next cycle; in-flight word dropped.
//  InReady=1 only in ACCEPT; accept = InValid & InReady. Fields sampled and encoded at accept.
//  ImWrEn=1 exactly one cycle (WRITE), the cycle after accept; ImWrAddr=Count at that time.
//  Count/ImWrAddr +1 at end of WRITE. Throughput 1 word / 2 cycles. No write in ERR.
//  Encoding (unused bits = 0):
//   LSL 000_Rd_Rs   LSR 001_Rd_Rs   XOR 0110_Rd_00   RXR 0111_Rd_00
//   LD 01000_Rd_0   ST 01001_Rd_0   JE 1000_0_Rs[1:0]_00   JNE 1000_1_Rs[1:0]_00
//   SPC 1001_Rs[1:0]_Flag_00   LUT 1010_Rd_Flag_0   CTC 101100_000   CPY 1100_Rd_00
//   OR 1101_Rd_Rs[1:0]   ADD 1110_Rd_00   SUB 1110_Rd_10   MOV 1111_Imm   HALT 1_1111_1111
//  Illegal: op>=17; OR with Rs>3; JE/JNE/SPC with Rs==0 or Rs>3; MOV Imm==31 (collides with HALT).
//  Full: after DEPTH-th write, Done=1, Full=1; further InValid ignored (InReady=0).
//  HALT as last legal slot (Count=DEPTH-1): written, Done=1, Full=1.
//  Done/Full/Error sticky until Start or Reset.
// CONFIGURATION
//  ENCODER_CHECKSUM_EN defined: Checksum = XOR of all ImWrData written since Start, updated with
//   each write (visible cycle after WRITE). Undefined: Checksum tied to 9'h000, no XOR logic built.
// TESTING
//  Start; MOV Imm=5 -> cycle after accept ImWrEn=1, Addr=0, Data=9'h1E5; Count=1.
//  LSL Rd=2 Rs=3 then JE Rs=2 -> Data 9'h013 @0, 9'h108 @1; InReady low during each WRITE.
//  SUB Rd=1, then HALT -> 9'h1C6 @0, 9'h1FF @1; Done=1, Full=0, InReady=0 thereafter.
//  OR Rd=1 Rs=5 -> no ImWrEn, Error=1, InReady=0; Start clears Error, Count=0.
//  DEPTH=4: five ADD Rd=0 -> 4 writes of 9'h1C0 @0-3, Done=1, Full=1, fifth never accepted.
//  Reset low mid-WRITE -> ImWrEn=0 same cycle, all outputs 0; with ENCODER_CHECKSUM_EN,
//   writes 9'h1E5,9'h013 -> Checksum=9'h1F6.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Program-load encoder for the 9-bit ISA. It accepts symbolic
//                instructions over a valid/ready handshake and encodes each one
//                into 9-bit machine code. The words are written one after
//                another into instruction memory, starting at address 0, until
//                a HALT is written or memory is full.
//                Optional feature macro: ENCODER_CHECKSUM_EN (running XOR
//                checksum of every written word).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
  parameter int A     = 8,
  parameter int DEPTH = 256
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         InValid,
  output logic         InReady,
  input  logic [4:0]   InOp,
  input  logic [2:0]   InRd,
  input  logic [2:0]   InRs,
  input  logic [4:0]   InImm,
  input  logic         InFlag,
  output logic         ImWrEn,
  output logic [A-1:0] ImWrAddr,
  output logic [8:0]   ImWrData,
  output logic [A:0]   Count,
  output logic         Done,
  output logic         Full,
  output logic         Error,
  output logic [8:0]   Checksum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [A:0] DEPTH_C  = (A+1)'(DEPTH);
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  state_t       state_q, state_d;
  logic [A:0]   count_q, count_d;
  logic [8:0]   data_q, data_d;
  logic         in_ready_q, in_ready_d;
  logic         wr_en_q, wr_en_d;
  logic         done_q, done_d;
  logic         full_q, full_d;
  logic         error_q, error_d;

  logic [8:0]   enc_word;
  logic         enc_legal;
  logic [A:0]   count_inc;
  logic         rs_pc_ok;

  // Encode the presented fields into a machine word and flag illegal combinations
  always_comb begin
    enc_word  = 9'h000;
    enc_legal = 1'b1;
    // pc-register selects for JE/JNE/SPC must be 1..3
    rs_pc_ok  = (InRs != 3'd0) && (InRs <= 3'd3);
    case (InOp)
      5'd0:  enc_word = {3'b000, InRd, InRs};
      5'd1:  enc_word = {3'b001, InRd, InRs};
      5'd2:  enc_word = {4'b0110, InRd, 2'b00};
      5'd3:  enc_word = {4'b0111, InRd, 2'b00};
      5'd4:  enc_word = {5'b01000, InRd, 1'b0};
      5'd5:  enc_word = {5'b01001, InRd, 1'b0};
      5'd6: begin
        enc_word  = {4'b1000, 1'b0, InRs[1:0], 2'b00};
        enc_legal = rs_pc_ok;
      end
      5'd7: begin
        enc_word  = {4'b1000, 1'b1, InRs[1:0], 2'b00};
        enc_legal = rs_pc_ok;
      end
      5'd8: begin
        enc_word  = {4'b1001, InRs[1:0], InFlag, 2'b00};
        enc_legal = rs_pc_ok;
      end
      5'd9:  enc_word = {4'b1010, InRd, InFlag, 1'b0};
      5'd10: enc_word = 9'b101100000;
      5'd11: enc_word = {4'b1100, InRd, 2'b00};
      5'd12: begin
        enc_word  = {4'b1101, InRd, InRs[1:0]};
        enc_legal = (InRs <= 3'd3);
      end
      5'd13: enc_word = {4'b1110, InRd, 2'b00};
      5'd14: enc_word = {4'b1110, InRd, 2'b10};
      5'd15: begin
        // Imm 31 would produce the HALT word, so it is refused
        enc_word  = {4'b1111, InImm};
        enc_legal = (InImm != 5'd31);
      end
      5'd16: enc_word = HALT_WORD;
      default: begin
        enc_word  = 9'h000;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic: Start overrides everything and drops any in-flight word
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    done_d    = done_q;
    full_d    = full_q;
    error_d   = error_q;
    count_inc = count_q + 1'b1;
    if (Start) begin
      state_d = S_ACCEPT;
      count_d = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (InValid) begin
            if (enc_legal) begin
              data_d  = enc_word;
              state_d = S_WRITE;
            end else begin
              error_d = 1'b1;
              state_d = S_ERR;
            end
          end
        end
        S_WRITE: begin
          count_d = count_inc;
          if ((data_q == HALT_WORD) || (count_inc == DEPTH_C)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            full_d  = (count_inc == DEPTH_C);
          end else begin
            state_d = S_ACCEPT;
          end
        end
        default: state_d = state_q;
      endcase
    end
    in_ready_d = (state_d == S_ACCEPT);
    wr_en_d    = (state_d == S_WRITE);
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      data_q     <= 9'h000;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      full_q     <= full_d;
      error_q    <= error_d;
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [8:0] cks_q, cks_d;

  // Running XOR of every word, folded in as its write completes
  always_comb begin
    cks_d = cks_q;
    if (Start) begin
      cks_d = 9'h000;
    end else if (state_q == S_WRITE) begin
      cks_d = cks_q ^ data_q;
    end
  end

  // Checksum register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cks_q <= 9'h000;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign Checksum = cks_q;
`else
  assign Checksum = 9'h000;
`endif

  assign InReady  = in_ready_q;
  assign ImWrEn   = wr_en_q;
  assign ImWrAddr = count_q[A-1:0];
  assign ImWrData = data_q;
  assign Count    = count_q;
  assign Done     = done_q;
  assign Full     = full_q;
  assign Error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Directed self-checking bench for instr_encoder_loader with a
//                full-size instance and a DEPTH=4 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  logic       clk;
  logic       rst_n;
  logic       start, in_valid, start4, valid4;
  logic [4:0] op;
  logic [2:0] rd, rs;
  logic [4:0] imm;
  logic       flag;

  logic       in_ready, wr_en, done, full, error;
  logic [7:0] wr_addr;
  logic [8:0] wr_data, cks;
  logic [8:0] count;

  logic       in_ready4, wr_en4, done4, full4, error4;
  logic [1:0] wr_addr4;
  logic [8:0] wr_data4, cks4;
  logic [2:0] count4;

  int n_checks = 0;
  int n_pass   = 0;

  instr_encoder_loader #(.A(8), .DEPTH(256)) u_dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .InValid(in_valid), .InReady(in_ready),
    .InOp(op), .InRd(rd), .InRs(rs), .InImm(imm), .InFlag(flag),
    .ImWrEn(wr_en), .ImWrAddr(wr_addr), .ImWrData(wr_data), .Count(count),
    .Done(done), .Full(full), .Error(error), .Checksum(cks)
  );

  instr_encoder_loader #(.A(2), .DEPTH(4)) u_dut4 (
    .Clk(clk), .Reset(rst_n), .Start(start4), .InValid(valid4), .InReady(in_ready4),
    .InOp(op), .InRd(rd), .InRs(rs), .InImm(imm), .InFlag(flag),
    .ImWrEn(wr_en4), .ImWrAddr(wr_addr4), .ImWrData(wr_data4), .Count(count4),
    .Done(done4), .Full(full4), .Error(error4), .Checksum(cks4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic pulse_start4();
    tick(); start4 = 1'b1;
    tick(); start4 = 1'b0;
  endtask

  task automatic set_fields(input logic [4:0] o, input logic [2:0] d, input logic [2:0] s,
                            input logic [4:0] im, input logic f);
    op = o; rd = d; rs = s; imm = im; flag = f;
  endtask

  // Present one instruction to the main instance and check its write cycle
  task automatic send(input string tag, input logic [4:0] o, input logic [2:0] d,
                      input logic [2:0] s, input logic [4:0] im, input logic f,
                      input logic [8:0] exp_data, input logic [7:0] exp_addr);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, in_ready, 1);
    set_fields(o, d, s, im, f);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_wren"}, wr_en, 1);
    check({tag, "_addr"}, wr_addr, exp_addr);
    check({tag, "_data"}, wr_data, exp_data);
    check({tag, "_rdy_low"}, in_ready, 0);
    tick();
  endtask

  // Present an illegal instruction and check the rejection
  task automatic send_bad(input string tag, input logic [4:0] o, input logic [2:0] d,
                          input logic [2:0] s, input logic [4:0] im);
    pulse_start();
    set_fields(o, d, s, im, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_wren"}, wr_en, 0);
    check({tag, "_err"}, error, 1);
    check({tag, "_rdy"}, in_ready, 0);
    tick();
    check({tag, "_nowr"}, wr_en, 0);
  endtask

  initial begin
    logic [8:0] exp_cks;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; start4 = 1'b0; valid4 = 1'b0;
    set_fields(5'd0, 3'd0, 3'd0, 5'd0, 1'b0);
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_wren", wr_en, 0);
    check("rst_count", count, 0);
    check("rst_flags", {done, full, error}, 0);
    check("rst_cks", cks, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", in_ready, 0);

    // MOV Imm=5
    pulse_start();
    check("start_count", count, 0);
    check("start_ready", in_ready, 1);
    send("mov5", 5'd15, 3'd0, 3'd0, 5'd5, 1'b0, 9'h1E5, 8'd0);
    check("mov5_count", count, 1);

    // LSL then JE
    pulse_start();
    send("lsl", 5'd0, 3'd2, 3'd3, 5'd0, 1'b0, 9'h013, 8'd0);
    send("je", 5'd6, 3'd0, 3'd2, 5'd0, 1'b0, 9'h108, 8'd1);
    check("je_count", count, 2);

    // Other encodings in one run
    pulse_start();
    send("lsr", 5'd1, 3'd5, 3'd6, 5'd0, 1'b0, 9'h06E, 8'd0);
    send("xor", 5'd2, 3'd7, 3'd0, 5'd0, 1'b0, 9'h0DC, 8'd1);
    send("st",  5'd5, 3'd3, 3'd0, 5'd0, 1'b0, 9'h096, 8'd2);
    send("jne", 5'd7, 3'd0, 3'd3, 5'd0, 1'b0, 9'h11C, 8'd3);
    send("spc", 5'd8, 3'd0, 3'd1, 5'd0, 1'b1, 9'h12C, 8'd4);
    send("lut", 5'd9, 3'd4, 3'd0, 5'd0, 1'b1, 9'h152, 8'd5);
    send("ctc", 5'd10, 3'd0, 3'd0, 5'd0, 1'b0, 9'h160, 8'd6);
    send("or",  5'd12, 3'd2, 3'd3, 5'd0, 1'b0, 9'h1AB, 8'd7);
    check("multi_done", done, 0);

    // SUB then HALT
    pulse_start();
    send("sub", 5'd14, 3'd1, 3'd0, 5'd0, 1'b0, 9'h1C6, 8'd0);
    send("halt", 5'd16, 3'd0, 3'd0, 5'd0, 1'b0, 9'h1FF, 8'd1);
    check("halt_done", done, 1);
    check("halt_full", full, 0);
    check("halt_ready", in_ready, 0);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("halt_hold_ready", in_ready, 0);
    check("halt_hold_wren", wr_en, 0);

    // Illegal instructions
    send_bad("or_rs5", 5'd12, 3'd1, 3'd5, 5'd0);
    pulse_start();
    check("clr_err", error, 0);
    check("clr_count", count, 0);
    send_bad("je_rs0", 5'd6, 3'd0, 3'd0, 5'd0);
    send_bad("mov31", 5'd15, 3'd0, 3'd0, 5'd31);
    send_bad("op17", 5'd17, 3'd0, 3'd0, 5'd0);

    // DEPTH=4: five ADD Rd=0, the fifth never accepted
    pulse_start4();
    set_fields(5'd13, 3'd0, 3'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!in_ready4 && n < 20) begin tick(); n++; end
      check("d4_ready", in_ready4, 1);
      valid4 = 1'b1;
      tick();
      valid4 = 1'b0;
      check("d4_wren", wr_en4, 1);
      check("d4_addr", wr_addr4, i);
      check("d4_data", wr_data4, 9'h1C0);
      tick();
    end
    check("d4_done", done4, 1);
    check("d4_full", full4, 1);
    check("d4_count", count4, 4);
    valid4 = 1'b1;
    tick();
    check("d4_5th_wren", wr_en4, 0);
    tick();
    valid4 = 1'b0;
    check("d4_5th_ready", in_ready4, 0);
    check("d4_5th_count", count4, 4);

    // DEPTH=4: HALT in the last slot sets both Done and Full
    pulse_start4();
    check("d4h_clr_full", full4, 0);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!in_ready4 && n < 20) begin tick(); n++; end
      if (i == 3) set_fields(5'd16, 3'd0, 3'd0, 5'd0, 1'b0);
      else        set_fields(5'd13, 3'd0, 3'd0, 5'd0, 1'b0);
      valid4 = 1'b1;
      tick();
      valid4 = 1'b0;
      tick();
    end
    check("d4h_done", done4, 1);
    check("d4h_full", full4, 1);

    // Checksum over two writes, then reset in the middle of a write
`ifdef ENCODER_CHECKSUM_EN
    exp_cks = 9'h1F6;
`else
    exp_cks = 9'h000;
`endif
    pulse_start();
    send("ck_mov", 5'd15, 3'd0, 3'd0, 5'd5, 1'b0, 9'h1E5, 8'd0);
    send("ck_lsl", 5'd0, 3'd2, 3'd3, 5'd0, 1'b0, 9'h013, 8'd1);
    check("cks", cks, exp_cks);
    set_fields(5'd13, 3'd3, 3'd0, 5'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_wren_pre", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wren", wr_en, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_cks", cks, 0);
    check("mid_rst_ready", in_ready, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
